// File: rtl/fifo_pkg.sv
// Shared constants, width helpers and per-channel status payload for the multi-channel FIFO.
package fifo_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 16;
    localparam int unsigned DEF_N_CH   = 4;

    // Status count field is sized for the largest supported depth (2**15 words).
    localparam int unsigned CNT_W_MAX  = 16;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned ch_w_of(input int unsigned n_ch);
        return clog2_min1(n_ch);
    endfunction

    function automatic int unsigned aw_of(input int unsigned depth);
        return clog2_min1(depth);
    endfunction

    typedef struct packed {
        logic                 full;
        logic                 empty;
        logic                 almost_full;
        logic                 almost_empty;
        logic [CNT_W_MAX-1:0] count;
    } chan_status_t;

endpackage

// File: rtl/fifo_chan.sv
// One FIFO channel: circular buffer, occupancy, status decode and sticky error flags.
module fifo_chan
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned AF_LVL = DEF_DEPTH - 2,
    parameter int unsigned AE_LVL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] rd_data_c,
    output logic              pop_acc_c,
    output chan_status_t      status_c,
    output logic              ovf,
    output logic              udf
);

    localparam int unsigned AW = aw_of(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic full_c;
    logic empty_c;
    logic push_acc_c;
    logic ovf_set_c;
    logic udf_set_c;

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);

    // A full channel still takes a push when a pop frees a slot in the same cycle.
    assign push_acc_c = push & ~flush & (~full_c | pop);
    assign pop_acc_c  = pop  & ~flush & ~empty_c;
    assign ovf_set_c  = push & ~flush & full_c & ~pop;
    assign udf_set_c  = pop  & ~flush & empty_c;

    assign rd_data_c = mem[rd_ptr];

    always_comb begin
        status_c              = '0;
        status_c.full         = full_c;
        status_c.empty        = empty_c;
        status_c.almost_full  = (count >= CW'(AF_LVL));
        status_c.almost_empty = (count <= CW'(AE_LVL));
        status_c.count        = CNT_W_MAX'(count);
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push_acc_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_acc_c)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_acc_c, pop_acc_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Setting a flag takes priority over clearing it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf_set_c | (ovf & ~err_clr);
            udf <= udf_set_c | (udf & ~err_clr);
        end
    end

endmodule

// File: rtl/fifo_sync_mc.sv
// Multi-channel synchronous FIFO: N_CH independent channels sharing one push and one pop port.
module fifo_sync_mc
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned N_CH   = DEF_N_CH,
    parameter int unsigned AF_LVL = DEPTH - 2,
    parameter int unsigned AE_LVL = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  push,
    input  logic [ch_w_of(N_CH)-1:0]              push_ch,
    input  logic [DATA_W-1:0]                     push_data,
    input  logic                                  pop,
    input  logic [ch_w_of(N_CH)-1:0]              pop_ch,
    output logic [DATA_W-1:0]                     pop_data,
    output logic                                  pop_valid,
    input  logic [N_CH-1:0]                       flush,
    input  logic                                  err_clr,
    output logic [N_CH-1:0]                       full,
    output logic [N_CH-1:0]                       empty,
    output logic [N_CH-1:0]                       almost_full,
    output logic [N_CH-1:0]                       almost_empty,
    output logic [N_CH*(aw_of(DEPTH)+1)-1:0]      count,
    output logic [N_CH-1:0]                       ovf,
    output logic [N_CH-1:0]                       udf
);

    localparam int unsigned CH_W     = ch_w_of(N_CH);
    localparam int unsigned AW       = aw_of(DEPTH);
    localparam int unsigned CW       = AW + 1;
    localparam int unsigned CH_SLOTS = 1 << CH_W;

    logic [DATA_W-1:0] rd_data_c [CH_SLOTS];
    logic [N_CH-1:0]   pop_acc_c;
    chan_status_t      st_c [N_CH];
    logic [N_CH-1:0]   unused_cnt_bits;
    logic              pop_hit_c;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        fifo_chan #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AF_LVL (AF_LVL),
            .AE_LVL (AE_LVL)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .push      (push && (push_ch == CH_W'(i))),
            .pop       (pop  && (pop_ch  == CH_W'(i))),
            .flush     (flush[i]),
            .err_clr   (err_clr),
            .push_data (push_data),
            .rd_data_c (rd_data_c[i]),
            .pop_acc_c (pop_acc_c[i]),
            .status_c  (st_c[i]),
            .ovf       (ovf[i]),
            .udf       (udf[i])
        );

        assign full[i]            = st_c[i].full;
        assign empty[i]           = st_c[i].empty;
        assign almost_full[i]     = st_c[i].almost_full;
        assign almost_empty[i]    = st_c[i].almost_empty;
        assign count[i*CW +: CW]  = st_c[i].count[CW-1:0];
        assign unused_cnt_bits[i] = ^st_c[i].count;
    end

    // Channel select codes beyond N_CH read as zero and never pop.
    for (genvar j = N_CH; j < CH_SLOTS; j++) begin : g_pad
        assign rd_data_c[j] = '0;
    end

    assign pop_hit_c = |pop_acc_c;

    // Registered read port shared by all channels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else begin
            pop_valid <= pop_hit_c;
            if (pop_hit_c) begin
                pop_data <= rd_data_c[pop_ch];
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync_mc.sv
// Directed self-checking bench for fifo_sync_mc with default parameters.
module tb_fifo_sync_mc;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned N_CH   = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned CW     = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              push;
    logic [CH_W-1:0]   push_ch;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic [CH_W-1:0]   pop_ch;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic [N_CH-1:0]   flush;
    logic              err_clr;
    logic [N_CH-1:0]   full, empty, almost_full, almost_empty;
    logic [N_CH*CW-1:0] count;
    logic [N_CH-1:0]   ovf, udf;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_sync_mc dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_ch      (push_ch),
        .push_data    (push_data),
        .pop          (pop),
        .pop_ch       (pop_ch),
        .pop_data     (pop_data),
        .pop_valid    (pop_valid),
        .flush        (flush),
        .err_clr      (err_clr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .ovf          (ovf),
        .udf          (udf)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] cnt(input int ch);
        return count[ch*CW +: CW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; push_ch = '0; push_data = '0;
        pop = 1'b0; pop_ch = '0; flush = '0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (empty !== 4'hF) begin n_fail++; $display("FAIL reset_empty got %h exp F", empty); end
        n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %h exp 0", count); end
        n_tests++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pop_valid got %b exp 0", pop_valid); end
        n_tests++; if ({ovf, udf} !== 8'h00) begin n_fail++; $display("FAIL reset_flags got ovf=%h udf=%h exp 0", ovf, udf); end
        n_tests++; if ({full, almost_full, almost_empty} !== 12'h00F) begin n_fail++; $display("FAIL reset_status got f=%h af=%h ae=%h", full, almost_full, almost_empty); end
        rst = 1'b1;
        tick();
    endtask

    // Push 0..19 to ch2; pops start on the 9th push cycle and then drain.
    task automatic test_fill_wrap();
        int exp_cnt;
        for (int c = 0; c < 28; c++) begin
            idle();
            push = (c < 20); push_ch = 2'd2; push_data = DATA_W'(c);
            pop  = (c >= 8); pop_ch = 2'd2;
            tick();
            exp_cnt = (c < 8) ? c + 1 : ((c < 20) ? 8 : 27 - c);
            n_tests++; if (cnt(2) !== CW'(exp_cnt)) begin n_fail++; $display("FAIL wrap_count c=%0d got %0d exp %0d", c, cnt(2), exp_cnt); end
            n_tests++; if (pop_valid !== (c >= 8)) begin n_fail++; $display("FAIL wrap_valid c=%0d got %b", c, pop_valid); end
            if (c >= 8) begin
                n_tests++; if (pop_data !== DATA_W'(c - 8)) begin n_fail++; $display("FAIL wrap_data c=%0d got %h exp %h", c, pop_data, c - 8); end
            end
        end
        idle();
        n_tests++; if (empty[2] !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b exp 1", empty[2]); end
    endtask

    task automatic test_full_boundary();
        for (int k = 0; k < 16; k++) begin
            idle(); push = 1'b1; push_ch = 2'd1; push_data = 8'h40 + DATA_W'(k);
            tick();
        end
        idle();
        n_tests++; if (cnt(1) !== 5'd16 || full[1] !== 1'b1 || almost_full[1] !== 1'b1) begin n_fail++; $display("FAIL full_fill got cnt=%0d full=%b af=%b exp 16 1 1", cnt(1), full[1], almost_full[1]); end
        push = 1'b1; push_ch = 2'd1; push_data = 8'hEE; pop = 1'b1; pop_ch = 2'd1;
        tick();
        idle();
        n_tests++; if (cnt(1) !== 5'd16 || ovf[1] !== 1'b0) begin n_fail++; $display("FAIL full_pushpop got cnt=%0d ovf=%b exp 16 0", cnt(1), ovf[1]); end
        n_tests++; if (pop_valid !== 1'b1 || pop_data !== 8'h40) begin n_fail++; $display("FAIL full_pop_data got v=%b d=%h exp 1 40", pop_valid, pop_data); end
        push = 1'b1; push_ch = 2'd1; push_data = 8'hDD;
        tick();
        idle();
        n_tests++; if (cnt(1) !== 5'd16 || ovf[1] !== 1'b1) begin n_fail++; $display("FAIL full_ovf got cnt=%0d ovf=%b exp 16 1", cnt(1), ovf[1]); end
        n_tests++; if (pop_valid !== 1'b0 || pop_data !== 8'h40) begin n_fail++; $display("FAIL full_hold got v=%b d=%h exp 0 40", pop_valid, pop_data); end
    endtask

    task automatic test_empty_boundary();
        idle();
        push = 1'b1; push_ch = 2'd0; push_data = 8'hA5; pop = 1'b1; pop_ch = 2'd0;
        tick();
        idle();
        n_tests++; if (udf[0] !== 1'b1 || pop_valid !== 1'b0 || cnt(0) !== 5'd1) begin n_fail++; $display("FAIL empty_udf got udf=%b v=%b cnt=%0d exp 1 0 1", udf[0], pop_valid, cnt(0)); end
        pop = 1'b1; pop_ch = 2'd0;
        tick();
        idle();
        n_tests++; if (pop_valid !== 1'b1 || pop_data !== 8'hA5 || cnt(0) !== 5'd0) begin n_fail++; $display("FAIL empty_pop got v=%b d=%h cnt=%0d exp 1 a5 0", pop_valid, pop_data, cnt(0)); end
    endtask

    task automatic test_flush_errclr();
        for (int k = 0; k < 5; k++) begin
            idle(); push = 1'b1; push_ch = 2'd3; push_data = 8'h30 + DATA_W'(k);
            tick();
        end
        idle();
        n_tests++; if (cnt(3) !== 5'd5) begin n_fail++; $display("FAIL flush_fill got %0d exp 5", cnt(3)); end
        flush = 4'b1000; push = 1'b1; push_ch = 2'd3; push_data = 8'h99;
        tick();
        idle();
        n_tests++; if (cnt(3) !== 5'd0 || ovf[3] !== 1'b0 || empty[3] !== 1'b1) begin n_fail++; $display("FAIL flush_push got cnt=%0d ovf=%b empty=%b exp 0 0 1", cnt(3), ovf[3], empty[3]); end
        // Flushing the full ch1 under a pop must not produce a read.
        flush = 4'b0010; pop = 1'b1; pop_ch = 2'd1;
        tick();
        idle();
        n_tests++; if (cnt(1) !== 5'd0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL flush_pop got cnt=%0d v=%b exp 0 0", cnt(1), pop_valid); end
        n_tests++; if (ovf !== 4'b0010 || udf !== 4'b0001) begin n_fail++; $display("FAIL sticky got ovf=%b udf=%b exp 0010 0001", ovf, udf); end
        err_clr = 1'b1; pop = 1'b1; pop_ch = 2'd2;
        tick();
        idle();
        n_tests++; if (ovf !== 4'b0000 || udf !== 4'b0100) begin n_fail++; $display("FAIL errclr_set_wins got ovf=%b udf=%b exp 0000 0100", ovf, udf); end
        err_clr = 1'b1;
        tick();
        idle();
        n_tests++; if (ovf !== 4'b0000 || udf !== 4'b0000) begin n_fail++; $display("FAIL errclr got ovf=%b udf=%b exp 0", ovf, udf); end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 8; k++) begin
            idle(); push = 1'b1; push_ch = 2'd0; push_data = 8'h70 + DATA_W'(k);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            idle(); push = 1'b1; push_ch = 2'd1; push_data = 8'h20 + DATA_W'(k);
            tick();
        end
        idle();
        push = 1'b1; push_ch = 2'd1; push_data = 8'h22; pop = 1'b1; pop_ch = 2'd0;
        tick();
        idle();
        n_tests++; if (cnt(0) !== 5'd7 || cnt(1) !== 5'd3) begin n_fail++; $display("FAIL indep_count got c0=%0d c1=%0d exp 7 3", cnt(0), cnt(1)); end
        n_tests++; if (pop_valid !== 1'b1 || pop_data !== 8'h70) begin n_fail++; $display("FAIL indep_pop got v=%b d=%h exp 1 70", pop_valid, pop_data); end
        #2 rst = 1'b0;
        #1;
        n_tests++; if (count !== '0 || empty !== 4'hF || almost_empty !== 4'hF) begin n_fail++; $display("FAIL async_status got cnt=%h empty=%h ae=%h", count, empty, almost_empty); end
        n_tests++; if (pop_valid !== 1'b0 || pop_data !== 8'h00) begin n_fail++; $display("FAIL async_pop got v=%b d=%h exp 0 00", pop_valid, pop_data); end
        tick();
        rst = 1'b1;
        push = 1'b1; push_ch = 2'd0; push_data = 8'h5A;
        tick();
        idle();
        pop = 1'b1; pop_ch = 2'd0;
        tick();
        idle();
        n_tests++; if (pop_valid !== 1'b1 || pop_data !== 8'h5A || cnt(0) !== 5'd0) begin n_fail++; $display("FAIL post_reset got v=%b d=%h cnt=%0d exp 1 5a 0", pop_valid, pop_data, cnt(0)); end
    endtask

    initial begin
        idle();
        rst = 1'b0;
        test_reset();
        test_fill_wrap();
        test_full_boundary();
        test_empty_boundary();
        test_flush_errclr();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
